// File: rtl/src_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : src_control_sequencer
// Description : Hardwired fetch/decode/execute control unit for the Mini SRC
//               datapath. Strobes are Moore-decoded from state and IR.
// Revision    : 1.0 - initial release
// ============================================================================
module src_control_sequencer #(
    parameter int DATA_W  = 32,
    parameter int OPC_W   = 5,
    parameter int STATE_W = 4
) (
    input  logic               Clock,
    input  logic               clear,
    input  logic [DATA_W-1:0]  IR,
    input  logic               Stop,
    output logic               PCout,
    output logic               Zlowout,
    output logic               Zhighout,
    output logic               MDRout,
    output logic               HIout,
    output logic               LOout,
    output logic               Cout,
    output logic               MARin,
    output logic               Zin,
    output logic               PCin,
    output logic               MDRin,
    output logic               IRin,
    output logic               Yin,
    output logic               LOin,
    output logic               HIin,
    output logic               IncPC,
    output logic               Read,
    output logic               Gra,
    output logic               Grb,
    output logic               Grc,
    output logic               Rin,
    output logic               Rout,
    output logic [OPC_W-1:0]   alu_op,
    output logic               Run,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    typedef enum logic [STATE_W-1:0] {
        T0_RST, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    localparam logic [OPC_W-1:0] c_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] c_OR   = 5'b01011;
    localparam logic [OPC_W-1:0] c_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] c_ORI  = 5'b01110;
    localparam logic [OPC_W-1:0] c_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] c_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] c_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] c_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] c_MFHI = 5'b11000;
    localparam logic [OPC_W-1:0] c_MFLO = 5'b11001;
    localparam logic [OPC_W-1:0] c_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] c_HALT = 5'b11011;

    state_t           r_state;
    state_t           w_next;
    state_t           w_end;
    logic [OPC_W-1:0] w_opc;
    logic             w_ralu, w_imm, w_muldiv, w_negnot, w_mfhi, w_mflo, w_nop, w_halt;
    logic             w_unused_ir;

    assign w_opc       = IR[DATA_W-1 -: OPC_W];
    assign w_unused_ir = ^IR[DATA_W-OPC_W-1:0];

    assign w_ralu   = (w_opc >= c_ADD)  && (w_opc <= c_OR);
    assign w_imm    = (w_opc >= c_ADDI) && (w_opc <= c_ORI);
    assign w_muldiv = (w_opc == c_MUL)  || (w_opc == c_DIV);
    assign w_negnot = (w_opc == c_NEG)  || (w_opc == c_NOT);
    assign w_mfhi   = (w_opc == c_MFHI);
    assign w_mflo   = (w_opc == c_MFLO);
    assign w_nop    = (w_opc == c_NOP);
    assign w_halt   = (w_opc == c_HALT);

    // Stop is honoured only at the instruction boundary, never mid-execute.
    assign w_end = Stop ? HALT : T0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            T0_RST: w_next = T0;
            T0:     w_next = T1;
            T1:     w_next = T2;
            T2:     w_next = T3;
            T3: begin
                if (w_halt)
                    w_next = HALT;
                else if (w_ralu || w_imm || w_muldiv || w_negnot)
                    w_next = T4;
                else
                    w_next = w_end;
            end
            T4:     w_next = w_negnot ? w_end : T5;
            T5:     w_next = w_muldiv ? T6 : w_end;
            T6:     w_next = w_end;
            HALT:   w_next = HALT;
            default: w_next = T0_RST;
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear)
            r_state <= T0_RST;
        else
            r_state <= w_next;
    end

    assign state_dbg = r_state;

    always_comb begin
        {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin}       = '0;
        {IncPC, Read, Gra, Grb, Grc, Rin, Rout}                = '0;
        alu_op     = '0;
        illegal_op = 1'b0;
        Run        = (r_state != T0_RST) && (r_state != HALT);
        case (r_state)
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                alu_op = c_ADD;
            end
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            T3: begin
                if (w_ralu || w_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (w_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (w_negnot) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_opc;
                end else if (w_mfhi) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_mflo) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (!(w_nop || w_halt)) begin
                    illegal_op = 1'b1;
                end
            end
            T4: begin
                if (w_ralu) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_opc;
                end else if (w_imm) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = w_opc;
                end else if (w_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_opc;
                end else if (w_negnot) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            T5: begin
                if (w_muldiv) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else if (w_ralu || w_imm) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_src_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_src_control_sequencer
// Description : Directed self-checking bench for the Mini SRC control unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_src_control_sequencer;

    localparam logic [21:0] PCOUT = 22'd1 << 21, ZLOW  = 22'd1 << 20, ZHIGH = 22'd1 << 19;
    localparam logic [21:0] MDROUT = 22'd1 << 18, HIOUT = 22'd1 << 17, LOOUT = 22'd1 << 16;
    localparam logic [21:0] COUT  = 22'd1 << 15, MARIN = 22'd1 << 14, ZIN   = 22'd1 << 13;
    localparam logic [21:0] PCIN  = 22'd1 << 12, MDRIN = 22'd1 << 11, IRIN  = 22'd1 << 10;
    localparam logic [21:0] YIN   = 22'd1 << 9,  LOIN  = 22'd1 << 8,  HIIN  = 22'd1 << 7;
    localparam logic [21:0] INCPC = 22'd1 << 6,  READ  = 22'd1 << 5,  GRA   = 22'd1 << 4;
    localparam logic [21:0] GRB   = 22'd1 << 3,  GRC   = 22'd1 << 2,  RIN   = 22'd1 << 1;
    localparam logic [21:0] ROUT  = 22'd1;
    localparam logic [21:0] NONE  = 22'd0;

    localparam logic [3:0] ST_RST = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3;
    localparam logic [3:0] ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7;
    localparam logic [3:0] ST_HALT = 4'd8;

    logic        Clock = 1'b0;
    logic        clear, Stop;
    logic [31:0] IR;
    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
    logic IncPC, Read, Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  alu_op;
    logic        Run, illegal_op;
    logic [3:0]  state_dbg;
    logic [21:0] strobes;

    int n_tests = 0;
    int n_fail  = 0;

    src_control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .LOin(LOin), .HIin(HIin),
        .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .Run(Run), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 Clock = ~Clock;

    assign strobes = {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout,
                      MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
                      IncPC, Read, Gra, Grb, Grc, Rin, Rout};

    task automatic check_now(input string tag, input logic [21:0] s, input logic [4:0] a,
                             input logic ill, input logic [3:0] st);
        logic        run;
        logic [32:0] exp_v, obs_v;
        run   = (st != ST_RST) && (st != ST_HALT);
        exp_v = {s, a, run, ill, st};
        obs_v = {strobes, alu_op, Run, illegal_op, state_dbg};
        n_tests++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
        end
        n_tests++;
        assert ($onehot0(strobes[21:15]) && !(Rin && Yin)) else begin
            n_fail++;
            $error("FAIL %s_bus observed=%b expected=onehot0_bus_no_rin_yin", tag, strobes);
        end
    endtask

    task automatic tick_chk(input string tag, input logic [21:0] s, input logic [4:0] a,
                            input logic ill, input logic [3:0] st);
        @(posedge Clock);
        #1;
        check_now(tag, s, a, ill, st);
    endtask

    task automatic fetch_rest(input string tag);
        tick_chk({tag, "_t1"}, ZLOW | PCIN | READ | MDRIN, 5'd0, 1'b0, ST_T1);
        tick_chk({tag, "_t2"}, MDROUT | IRIN, 5'd0, 1'b0, ST_T2);
    endtask

    localparam logic [21:0] T0S = PCOUT | MARIN | INCPC | ZIN;

    initial begin
        clear = 1'b0; Stop = 1'b0; IR = 32'h0;
        #12;
        check_now("reset", NONE, 5'd0, 1'b0, ST_RST);
        @(negedge Clock); clear = 1'b1;
        tick_chk("rel_t0", T0S, 5'b00011, 1'b0, ST_T0);

        IR = 32'h50918000;                      // and R1,R2,R3
        fetch_rest("and");
        tick_chk("and_t3", GRB | ROUT | YIN, 5'd0, 1'b0, ST_T3);
        tick_chk("and_t4", GRC | ROUT | ZIN, 5'b01010, 1'b0, ST_T4);
        tick_chk("and_t5", ZLOW | GRA | RIN, 5'd0, 1'b0, ST_T5);
        tick_chk("and_t0", T0S, 5'b00011, 1'b0, ST_T0);

        IR = 32'h7A080000;                      // mul R4,R1
        fetch_rest("mul");
        tick_chk("mul_t3", GRA | ROUT | YIN, 5'd0, 1'b0, ST_T3);
        tick_chk("mul_t4", GRB | ROUT | ZIN, 5'b01111, 1'b0, ST_T4);
        tick_chk("mul_t5", ZLOW | LOIN, 5'd0, 1'b0, ST_T5);
        tick_chk("mul_t6", ZHIGH | HIIN, 5'd0, 1'b0, ST_T6);
        tick_chk("mul_t0", T0S, 5'b00011, 1'b0, ST_T0);

        IR = 32'h6A180005;                      // andi R4,R3,5
        fetch_rest("andi");
        tick_chk("andi_t3", GRB | ROUT | YIN, 5'd0, 1'b0, ST_T3);
        tick_chk("andi_t4", COUT | ZIN, 5'b01101, 1'b0, ST_T4);
        tick_chk("andi_t5", ZLOW | GRA | RIN, 5'd0, 1'b0, ST_T5);
        tick_chk("andi_t0", T0S, 5'b00011, 1'b0, ST_T0);

        IR = 32'h88000000;                      // neg
        fetch_rest("neg");
        tick_chk("neg_t3", GRB | ROUT | ZIN, 5'b10001, 1'b0, ST_T3);
        tick_chk("neg_t4", ZLOW | GRA | RIN, 5'd0, 1'b0, ST_T4);
        tick_chk("neg_t0", T0S, 5'b00011, 1'b0, ST_T0);

        IR = 32'hC0000000;                      // mfhi
        fetch_rest("mfhi");
        tick_chk("mfhi_t3", HIOUT | GRA | RIN, 5'd0, 1'b0, ST_T3);
        tick_chk("mfhi_t0", T0S, 5'b00011, 1'b0, ST_T0);

        IR = 32'hC8000000;                      // mflo
        fetch_rest("mflo");
        tick_chk("mflo_t3", LOOUT | GRA | RIN, 5'd0, 1'b0, ST_T3);
        tick_chk("mflo_t0", T0S, 5'b00011, 1'b0, ST_T0);

        IR = 32'hD0000000;                      // nop
        fetch_rest("nop");
        tick_chk("nop_t3", NONE, 5'd0, 1'b0, ST_T3);
        tick_chk("nop_t0", T0S, 5'b00011, 1'b0, ST_T0);

        IR = 32'h00000000;                      // ld: unsupported
        fetch_rest("ld");
        tick_chk("ld_t3", NONE, 5'd0, 1'b1, ST_T3);
        tick_chk("ld_t0", T0S, 5'b00011, 1'b0, ST_T0);

        IR = 32'h18000000;                      // add, aborted in T4
        fetch_rest("abort");
        tick_chk("abort_t3", GRB | ROUT | YIN, 5'd0, 1'b0, ST_T3);
        tick_chk("abort_t4", GRC | ROUT | ZIN, 5'b00011, 1'b0, ST_T4);
        #2 clear = 1'b0;
        #1 check_now("abort_clr", NONE, 5'd0, 1'b0, ST_RST);
        @(negedge Clock); clear = 1'b1;
        tick_chk("abort_t0", T0S, 5'b00011, 1'b0, ST_T0);

        fetch_rest("stop");                     // add with Stop raised mid-execute
        tick_chk("stop_t3", GRB | ROUT | YIN, 5'd0, 1'b0, ST_T3);
        Stop = 1'b1;
        tick_chk("stop_t4", GRC | ROUT | ZIN, 5'b00011, 1'b0, ST_T4);
        tick_chk("stop_t5", ZLOW | GRA | RIN, 5'd0, 1'b0, ST_T5);
        tick_chk("stop_halt", NONE, 5'd0, 1'b0, ST_HALT);
        Stop = 1'b0;
        for (int i = 0; i < 5; i++) tick_chk("stop_hold", NONE, 5'd0, 1'b0, ST_HALT);

        #2 clear = 1'b0;
        #1 check_now("halt_clr", NONE, 5'd0, 1'b0, ST_RST);
        @(negedge Clock); clear = 1'b1;
        tick_chk("halt_t0", T0S, 5'b00011, 1'b0, ST_T0);
        IR = 32'hD8000000;                      // halt
        fetch_rest("halt");
        tick_chk("halt_t3", NONE, 5'd0, 1'b0, ST_T3);
        for (int i = 0; i < 20; i++) tick_chk("halt_hold", NONE, 5'd0, 1'b0, ST_HALT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
